mdu_ctrl: RTL and testbench

- Iterative multiply/divide unit and controller for the CPU's MULT/MULTU/DIV/DIVU operations, which the single-cycle ALU does not compute.
- Owns the HI/LO architectural registers and sequences a 32-step shift-add multiplier or a restoring divider.
- Exposes busy/done to the pipeline for stall control, and supplies HI/LO to the ALU's MFHI/MFLO path.

---
 rtl/mdu_ctrl.sv | 140 ++++++++++++++
 tb/tb_mdu_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers
module mdu_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CALC   = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic               div_q, div_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    m_d     = m_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    a_mag = (op[0] && src_a[WIDTH-1]) ? -src_a : src_a;
    b_mag = (op[0] && src_b[WIDTH-1]) ? -src_b : src_b;

    // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, m_q};

    case (state_q)
      S_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start && !flush) begin
          state_d = S_CALC;
          count_d = '0;
          div_d   = op[1];
          neg_d   = op[0] && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
          rneg_d  = op[0] && src_a[WIDTH-1];
          m_d     = op[1] ? b_mag : a_mag;
          acc_d   = {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          if (!div_q)
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          else if (!div_diff[WIDTH])
            acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else
            acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          count_d = count_q + 1'b1;
          if (count_q == LAST_ITER) state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (!div_q) begin
            {hi_d, lo_d} = neg_q ? -acc_q : acc_q;
          end else if (m_q != '0) begin
            // a zero divisor still runs the full sequence but leaves HI/LO alone
            lo_d = neg_q  ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
            hi_d = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      m_q     <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - directed and random checks of mdu_ctrl against an arithmetic model
module tb_mdu_ctrl;

  logic        clk, rst, start, flush, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] src_a, src_b, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;
  logic [31:0] hi_m, lo_m;

  mdu_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Result {HI,LO} from the architectural definition of each operation.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] cur_hi, input logic [31:0] cur_lo);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'd0: res = {32'd0, a} * {32'd0, b};
      2'd1: res = 64'(sa * sb);
      2'd2: res = (b == 0) ? {cur_hi, cur_lo} : {a % b, a / b};
      default: begin
        if (b == 0) res = {cur_hi, cur_lo};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  // Issues one operation in cycle 0 and checks busy/done timing and the final HI/LO.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input logic wh, input logic [31:0] wd);
    int nbad;
    start = 1'b1; op = o; src_a = a; src_b = b;
    hi_we = wh; wdata = wd;
    tick();
    start = 1'b0; hi_we = 1'b0;
    if (wh) check({tag, "_same_cycle_mthi"}, {32'd0, hi}, {32'd0, wd});
    nbad = 0;
    for (int c = 1; c <= 33; c++) begin
      if (busy !== 1'b1 || done !== 1'b0) nbad++;
      if (c == 15) begin
        start = 1'b1; op = ~o; src_a = ~a; src_b = a;
      end else if (c == 16) begin
        start = 1'b0;
      end
      tick();
    end
    check({tag, "_busy_window"}, 64'(nbad), 64'd0);
    check({tag, "_done"}, {62'd0, done, busy}, {62'd0, 1'b1, 1'b0});
    check({tag, "_hilo"}, {hi, lo}, {exp_hi, exp_lo});
    hi_m = exp_hi; lo_m = exp_lo;
    tick();
    check({tag, "_done_drop"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    logic [63:0] r;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    int ndone;

    rst = 1'b1; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'd0; src_a = '0; src_b = '0; wdata = '0;
    hi_m = '0; lo_m = '0;
    #12;
    check("reset_out", {30'd0, busy, done}, 32'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    rst = 1'b0;
    tick();

    run_op("multu_max", 2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 32'd0);
    run_op("mult_neg",  2'd1, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b1, 32'hCAFEF00D);
    run_op("div_neg",   2'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 32'd0);
    run_op("divu",      2'd2, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, 1'b0, 32'd0);
    run_op("div_ovf",   2'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 32'd0);

    hi_we = 1'b1; wdata = 32'h12345678;
    tick();
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h9ABCDEF0;
    tick();
    lo_we = 1'b0;
    check("mthi_mtlo", {hi, lo}, 64'h12345678_9ABCDEF0);
    run_op("divu_zero", 2'd2, 32'd5, 32'd0, 32'h12345678, 32'h9ABCDEF0, 1'b0, 32'd0);

    start = 1'b1; op = 2'd0; src_a = 32'd7; src_b = 32'd9;
    tick();
    start = 1'b0;
    repeat (4) tick();
    hi_we = 1'b1; wdata = 32'hDEADBEEF;
    tick();
    hi_we = 1'b0;
    check("mthi_while_busy", {hi, lo}, {hi_m, lo_m});
    repeat (4) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", {63'd0, busy}, 64'd0);
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      if (done !== 1'b0) ndone++;
      tick();
    end
    check("flush_no_done", 64'(ndone), 64'd0);
    check("flush_hilo", {hi, lo}, {hi_m, lo_m});

    start = 1'b1; flush = 1'b1; op = 2'd0; src_a = 32'd3; src_b = 32'd3;
    tick();
    start = 1'b0; flush = 1'b0;
    check("flush_start_idle", {63'd0, busy}, 64'd0);

    for (int i = 0; i < 16; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFFFFFF;
        2: rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      r = model(ro, ra, rb, hi_m, lo_m);
      run_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, r[63:32], r[31:0], 1'b0, 32'd0);
    end

    if (lo_m == 32'd0) run_op("pre_rst", 2'd0, 32'd4, 32'd5, 32'd0, 32'd20, 1'b0, 32'd0);
    start = 1'b1; op = 2'd3; src_a = 32'hFFFFFFF9; src_b = 32'd2;
    tick();
    start = 1'b0;
    repeat (19) tick();
    #2 rst = 1'b1;
    #1;
    check("async_rst_out", {30'd0, busy, done}, 32'd0);
    check("async_rst_hilo", {hi, lo}, 64'd0);
    #2 rst = 1'b0;
    hi_m = '0; lo_m = '0;
    tick();
    run_op("multu_after_rst", 2'd0, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
